// File: rtl/control_pkg.sv
// Shared constants and types for the stepper direction controller.
package control_pkg;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

  localparam int SIGN_BIT = 7;
  localparam int MAG_MSB  = 6;

  typedef enum logic {CW = 1'b0, CCW = 1'b1} dir_e;

  // Coil pattern for a phase index.
  function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return PH0;
      2'd1:    return PH1;
      2'd2:    return PH2;
      default: return PH3;
    endcase
  endfunction

endpackage

// File: rtl/control_stepper_seq.sv
// Step sequencer: prescaler, phase index, remaining-step counter and coil decode.
module stepper_seq
  import control_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic         gclk_i,
  input  logic         grst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [MAG_MSB:0] load_mag_i,
  input  dir_e         load_dir_i,
  output logic [3:0]   m_out_o
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        phase_q, phase_d;
  logic [MAG_MSB:0]  rem_q, rem_d;
  dir_e              dir_q, dir_d;
  logic [3:0]        m_out_q, m_out_d;
  logic              stepped;

  // Next-state: a load aborts the current run without stepping; otherwise
  // step when the prescaler wraps. Coils stay lit through the final step.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    stepped = 1'b0;
    if (load_i) begin
      rem_d   = load_mag_i;
      presc_d = '0;
      dir_d   = load_dir_i;
    end else if (en_i && rem_q != '0) begin
      if (presc_q == PW'(STEP_DIV - 1)) begin
        presc_d = '0;
        phase_d = (dir_q == CW) ? phase_q + 2'd1 : phase_q - 2'd1;
        rem_d   = rem_q - 1'b1;
        stepped = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    m_out_d = (en_i && (rem_d != '0 || stepped)) ? phase_onehot(phase_d) : 4'b0000;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge gclk_i) begin
    if (!grst_ni) begin
      presc_q <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      dir_q   <= CW;
      m_out_q <= 4'b0000;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      m_out_q <= m_out_d;
    end
  end

  assign m_out_o = m_out_q;

endmodule

// File: rtl/control.sv
// Stepper direction controller top: command change detection/select,
// stepper sequencer, and the QR-triggered uniform ro_motor drive.
module control
  import control_pkg::*;
#(
  parameter int STEP_DIV = 1,
  parameter int RO_DIV   = 4
) (
  input  logic       PWM,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] geo_in,
  input  logic [7:0] gps_in,
  input  logic       QR_in,
  output logic [3:0] M_OUT,
  output logic       ro_motor
);

  localparam int RW = (RO_DIV > 1) ? $clog2(RO_DIV) : 1;

  logic [7:0]       geo_q, gps_q;
  logic             new_geo, new_gps, load;
  logic [MAG_MSB:0] load_mag;
  dir_e             load_dir;

  logic             latch_q, latch_d;
  logic [RW-1:0]    ro_cnt_q, ro_cnt_d;
  logic             ro_q, ro_d;

  assign new_geo  = EN && (geo_in != geo_q);
  assign new_gps  = EN && (gps_in != gps_q);
  assign load     = new_geo || new_gps;
  // gps takes priority and always drives clockwise.
  assign load_mag = new_gps ? gps_in[MAG_MSB:0] : geo_in[MAG_MSB:0];
  assign load_dir = new_gps ? CW : (geo_in[SIGN_BIT] ? CCW : CW);

  // Track the last enabled copy of each command input.
  always_ff @(posedge PWM) begin
    if (!RST) begin
      geo_q <= '0;
      gps_q <= '0;
    end else if (EN) begin
      geo_q <= geo_in;
      gps_q <= gps_in;
    end
  end

  stepper_seq #(.STEP_DIV(STEP_DIV)) u_seq (
    .gclk_i     (PWM),
    .grst_ni    (RST),
    .en_i       (EN),
    .load_i     (load),
    .load_mag_i (load_mag),
    .load_dir_i (load_dir),
    .m_out_o    (M_OUT)
  );

  // Sticky QR latch and the RO_DIV half-period square-wave divider.
  always_comb begin
    latch_d  = latch_q | (EN & QR_in);
    ro_cnt_d = '0;
    ro_d     = 1'b0;
    if (latch_q) begin
      if (ro_cnt_q == RW'(RO_DIV - 1)) begin
        ro_cnt_d = '0;
        ro_d     = ~ro_q;
      end else begin
        ro_cnt_d = ro_cnt_q + 1'b1;
        ro_d     = ro_q;
      end
    end
  end

  // QR latch / ro_motor state register.
  always_ff @(posedge PWM) begin
    if (!RST) begin
      latch_q  <= 1'b0;
      ro_cnt_q <= '0;
      ro_q     <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      ro_cnt_q <= ro_cnt_d;
      ro_q     <= ro_d;
    end
  end

  assign ro_motor = ro_q;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: random and directed commands against a
// step-counting behavioural model.
module tb_control;

  localparam int STEP_DIV = 1;
  localparam int RO_DIV   = 4;

  logic       PWM = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] geo_in = 8'h00;
  logic [7:0] gps_in = 8'h00;
  logic       QR_in = 1'b0;
  logic [3:0] M_OUT;
  logic       ro_motor;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int         m_rem, m_phase, m_presc;
  bit         m_ccw;
  logic [7:0] m_geo, m_gps;
  logic [3:0] exp_m;

  control #(.STEP_DIV(STEP_DIV), .RO_DIV(RO_DIV)) dut (
    .PWM(PWM), .RST(RST), .EN(EN), .geo_in(geo_in), .gps_in(gps_in),
    .QR_in(QR_in), .M_OUT(M_OUT), .ro_motor(ro_motor)
  );

  always #5 PWM = ~PWM;

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    bit newg, newp, took;
    took = 0;
    if (!RST) begin
      m_rem = 0; m_phase = 0; m_presc = 0; m_ccw = 0;
      m_geo = 0; m_gps = 0; exp_m = 4'b0000;
    end else begin
      newg = EN && (geo_in != m_geo);
      newp = EN && (gps_in != m_gps);
      if (EN) begin m_geo = geo_in; m_gps = gps_in; end
      if (newp) begin
        m_rem = int'(gps_in[6:0]); m_presc = 0; m_ccw = 0;
      end else if (newg) begin
        m_rem = int'(geo_in[6:0]); m_presc = 0; m_ccw = geo_in[7];
      end else if (EN && m_rem > 0) begin
        m_presc++;
        if (m_presc == STEP_DIV) begin
          m_presc = 0;
          m_phase = (m_phase + (m_ccw ? 3 : 1)) % 4;
          m_rem--;
          took = 1;
        end
      end
      exp_m = (EN && (m_rem > 0 || took)) ? 4'(1 << m_phase) : 4'b0000;
    end
    @(posedge PWM);
    #1;
  endtask

  task automatic test_reset();
    RST = 0; EN = 1; QR_in = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (M_OUT !== 4'b0000 || ro_motor !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: M_OUT=%b ro_motor=%b, required 0000/0", M_OUT, ro_motor);
      end
    end
  endtask

  task automatic run_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      n_tests++;
      if (M_OUT !== exp_m) begin
        n_fail++;
        $display("FAIL %s cycle %0d: M_OUT=%b, required %b", name, i, M_OUT, exp_m);
      end
    end
  endtask

  task automatic test_cw_geo();
    logic [3:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    RST = 1; EN = 1; geo_in = 8'h46;
    tick();  // capture edge
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (M_OUT !== seq[i % 4] || M_OUT !== exp_m) begin
        n_fail++;
        $display("FAIL cw_geo step %0d: M_OUT=%b, required %b", i, M_OUT, seq[i % 4]);
      end
    end
  endtask

  task automatic test_en_hold_ccw();
    EN = 0;
    run_cycles("en_low", 10);
    EN = 1; geo_in = 8'hC6;
    run_cycles("ccw_geo", 9);
  endtask

  task automatic test_gps_cw();
    EN = 0;
    run_cycles("gps_en_low", 3);
    EN = 1; gps_in = 8'hC6;
    run_cycles("gps_c6", 6);
    EN = 0;
    run_cycles("gps_en_low2", 3);
    EN = 1; gps_in = 8'h46;
    run_cycles("gps_46", 6);
  endtask

  task automatic test_short_run();
    int steps;
    geo_in = 8'h03;
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i > 0 && M_OUT != 4'b0000) steps++;
      n_tests++;
      if (M_OUT !== exp_m) begin
        n_fail++;
        $display("FAIL short_run cycle %0d: M_OUT=%b, required %b", i, M_OUT, exp_m);
      end
    end
    n_tests++;
    if (steps != 3) begin
      n_fail++;
      $display("FAIL short_run_count: steps=%0d, required 3", steps);
    end
  endtask

  task automatic test_same_edge();
    geo_in = 8'hC5; gps_in = 8'h02;
    run_cycles("same_edge", 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST    = ($urandom_range(0, 199) != 0);
      EN     = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 11) == 0) geo_in = 8'($urandom_range(0, 255) & 8'h8F);
      if ($urandom_range(0, 15) == 0) gps_in = 8'($urandom_range(0, 255) & 8'h87);
      tick();
      n_tests++;
      if (M_OUT !== exp_m) begin
        n_fail++;
        $display("FAIL random cycle %0d: M_OUT=%b, required %b", i, M_OUT, exp_m);
      end
    end
    RST = 1;
  endtask

  task automatic test_qr();
    int  t;
    bool_found: begin end
    RST = 1; EN = 1; QR_in = 0;
    run_cycles("qr_pre", 3);
    n_tests++;
    if (ro_motor !== 1'b0) begin
      n_fail++;
      $display("FAIL qr_pre: ro_motor=%b, required 0", ro_motor);
    end
    QR_in = 1;
    tick();
    EN = 0; QR_in = 0;
    t = 0;
    while (ro_motor !== 1'b1 && t <= RO_DIV + 1) begin
      tick();
      t++;
    end
    n_tests++;
    if (ro_motor !== 1'b1) begin
      n_fail++;
      $display("FAIL qr_first_rise: ro_motor=%b after %0d cycles, required 1 within %0d", ro_motor, t, RO_DIV + 1);
    end else begin
      for (int n = 1; n < 6 * RO_DIV; n++) begin
        tick();
        n_tests++;
        if (ro_motor !== (((n / RO_DIV) % 2) == 0) || M_OUT !== 4'b0000) begin
          n_fail++;
          $display("FAIL qr_toggle n=%0d: ro_motor=%b M_OUT=%b, required %b/0000",
                   n, ro_motor, M_OUT, ((n / RO_DIV) % 2) == 0);
        end
      end
    end
    RST = 0;
    tick();
    n_tests++;
    if (ro_motor !== 1'b0) begin
      n_fail++;
      $display("FAIL qr_reset: ro_motor=%b, required 0", ro_motor);
    end
    RST = 1; EN = 1;
    for (int i = 0; i < 2 * RO_DIV + 2; i++) begin
      tick();
      n_tests++;
      if (ro_motor !== 1'b0) begin
        n_fail++;
        $display("FAIL qr_cleared cycle %0d: ro_motor=%b, required 0", i, ro_motor);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cw_geo();
    test_en_hold_ccw();
    test_gps_cw();
    test_short_run();
    test_same_edge();
    test_random();
    test_qr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control.md
Name: control

Overview:
- 4-phase stepper-motor direction controller plus a constant-speed auxiliary motor drive.
- Takes a signed heading command (geo_in) and a latitude command (gps_in) and converts the most recent one into a counted run of stepper steps on M_OUT.
- A QR-scanner event latches a uniform square-wave drive on ro_motor.
- Sits between the sensor front-ends (compass/GPS/QR) and the motor driver pins.

Parameters:
- STEP_DIV, 1, clock cycles per stepper step (≥1).
- RO_DIV, 4, clock cycles per ro_motor half-period (≥1).

Ports:
- PWM  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous active-low reset.
- EN  input  1  enable; gates command capture and stepping.
- geo_in  input  8  heading command; bit7 = sign (0 = positive, 1 = negative), bits[6:0] = step count.
- gps_in  input  8  latitude command; bit7 = hemisphere (ignored for direction), bits[6:0] = step count.
- QR_in  input  1  QR code detected.
- M_OUT  output  4  one-hot stepper coil drive.
- ro_motor  output  1  uniform-rotation motor drive.

Behaviour:
- Interface: one clock (PWM); reset RST is synchronous and active-low. All state is updated only on rising PWM edges.
- Reset values: M_OUT = 0000, ro_motor = 0, phase index = 0, remaining = 0, prescalers = 0, QR latch = 0, geo_q = gps_q = 0, dir = CW.
- Change detection:
  - geo_q and gps_q hold the last enabled copies of geo_in and gps_in.
  - They update every cycle with EN = 1 and hold while EN = 0.
  - A new command exists when EN = 1 and the input differs from its copy.
- Command capture (edge where a new command exists):
  - remaining <= bits[6:0] of the changed input; step prescaler <= 0.
  - Direction for geo: CW if bit7 = 0, CCW if bit7 = 1.
  - Direction for gps: always CW, whatever bit7 is.
  - If geo and gps change on the same edge, gps wins.
  - A new command aborts any run in progress; no step is taken on the capture edge.
  - A command with magnitude 0 loads remaining = 0, so no steps are taken.
- Stepping (EN = 1, remaining > 0):
  - The prescaler counts 0..STEP_DIV-1. When it wraps, the phase advances by one and remaining decrements.
  - CW phase order: 0001 → 0010 → 0100 → 1000 → 0001.
  - CCW order is the reverse.
  - With STEP_DIV = 1: first step on the edge after capture, then one step per edge.
- M_OUT:
  - Registered one-hot of the current phase while EN = 1 and a run is active (remaining > 0, or the final step was just taken on this edge).
  - Otherwise 0000 (coils de-energised).
- EN = 0: no capture, no stepping, M_OUT = 0000. remaining, phase and direction are retained; the run resumes when EN returns to 1 with unchanged inputs.
- QR latch:
  - Set on any edge with EN = 1 and QR_in = 1.
  - Cleared only by reset. It does not depend on EN or QR_in after being set.
- ro_motor: while the latch is set, toggles every RO_DIV cycles (50% duty, period 2·RO_DIV); otherwise 0. It is independent of the stepper path.
- Reset mid-run: everything returns to its reset value on that edge.

Decomposition:
- Shared package: phase one-hot constants PH0..PH3 = 0001/0010/0100/1000, direction enum {CW, CCW}, command field positions (SIGN_BIT = 7, MAG_MSB = 6).
- One natural sub-module: stepper_seq (prescaler, phase index, remaining counter, one-hot decode).
- Command select and the QR/ro_motor divider stay in the top level.

Test Plan:
- RST = 0 for 10 cycles → M_OUT = 0000, ro_motor = 0. Then RST = 1, EN = 1, geo_in = 0x46 → 1 cycle after capture M_OUT = 0010, then 0100, 1000, 0001 (CW), with remaining falling from 70.
- EN = 0 for 10 cycles → M_OUT = 0000. EN = 1 with geo_in = 0xC6 → CCW sequence from the held phase, e.g. held 0010 gives 0001, 1000, 0100; remaining reloads 70.
- EN = 0, then EN = 1 with gps_in = 0xC6 → CW sequence despite bit7 = 1. The same again with gps_in = 0x46 → still CW.
- geo_in = 0x03 with defaults, EN held high → exactly 3 steps (0010, 0100, 1000), then M_OUT = 0000.
- EN = 1, QR_in = 1 for 1 cycle, then EN = 0 and QR_in = 0 → ro_motor toggles every 4 cycles indefinitely. RST = 0 → ro_motor = 0 and the latch is cleared.
- geo_in and gps_in change on the same enabled edge (0xC5, 0x02) → gps wins: 2 CW steps.
